// File: rtl/ofdm_pkg.sv
// Shared OFDM constants: sequencer state encoding, settings-bus defaults,
// counter width and a small saturating-increment helper.
package ofdm_pkg;

    localparam int CNT_W = 16;

    localparam logic [7:0] SR_MAX_SYMBOLS_ADDR = 8'd0;
    localparam logic [7:0] MAX_SYMBOLS_RESET   = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LTS_GI,
        ST_LTS,
        ST_SYM_CP,
        ST_SYM_DATA
    } seq_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ofdm_frame_sequencer_if.sv
// Sample stream bundle: 32-bit I/Q beat with valid/ready handshake and tlast.
interface ofdm_frame_sequencer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/ofdm_seg_counter.sv
// Segment beat counter: holds the beats remaining in the current segment,
// counting the present one. A load overrides the decrement so the next
// segment can be armed on the final beat of the previous one.
module ofdm_seg_counter
    import ofdm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_len,
    input  logic             beat,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    // Remaining-beat register: load wins, otherwise step down on each beat.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_len;
        end else if (beat && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/ofdm_frame_sequencer.sv
// OFDM frame sequencer: strips the long-preamble guard, cyclic prefixes and
// (by default) the long training symbols from an aligned sample stream and
// frames the data symbols with tlast, ending the frame after the decoded
// symbol count or after max_symbols symbols (timeout).
// Optional feature: define OFDM_FRAME_SEQ_PREAMBLE_OUT_EN to forward the two
// long training symbols as two framed bursts.
// Segment lengths are expected to be at least 2 (guard) and 1 (others).
module ofdm_frame_sequencer
    import ofdm_pkg::*;
#(
    parameter int         SYMBOL_LEN        = 64,
    parameter int         CYCLIC_PREFIX_LEN = 16,
    parameter int         LTS_GI_LEN        = 32,
    parameter logic [7:0] SR_MAX_SYMBOLS    = SR_MAX_SYMBOLS_ADDR
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           set_stb,
    input  logic [7:0]                     set_addr,
    input  logic [31:0]                    set_data,
    ofdm_frame_sequencer_if.slave          samples,
    input  logic                           sof,
    input  logic [7:0]                     num_symbols,
    input  logic                           num_symbols_valid,
    ofdm_frame_sequencer_if.master         framed,
    output logic                           eof,
    output logic                           frame_active,
    output logic [15:0]                    abort_cnt
);

    // The sof beat itself is guard sample 0, so only LTS_GI_LEN-1 remain.
    localparam logic [CNT_W-1:0] GI_LOAD  = CNT_W'(LTS_GI_LEN - 1);
    localparam logic [CNT_W-1:0] LTS_LOAD = CNT_W'(2 * SYMBOL_LEN);
    localparam logic [CNT_W-1:0] CP_LOAD  = CNT_W'(CYCLIC_PREFIX_LEN);
    localparam logic [CNT_W-1:0] SYM_LOAD = CNT_W'(SYMBOL_LEN);

    seq_state_t       state, state_next;
    logic             flush;
    logic             passing;
    logic             beat;
    logic             seg_load;
    logic [CNT_W-1:0] seg_len;
    logic             seg_last;
    logic             sym_end;
    logic [7:0]       sym_idx;
    logic             n_latched;
    logic [7:0]       n_value_q;
    logic             n_hit;
    logic             n_known;
    logic [7:0]       n_value;
    logic [7:0]       max_symbols;
    logic [7:0]       max_eff;
    logic             done_ok;
    logic             timeout;
    logic             frame_end;

    assign flush        = reset | clear;
    assign frame_active = (state != ST_IDLE);

`ifdef OFDM_FRAME_SEQ_PREAMBLE_OUT_EN
    localparam logic [CNT_W-1:0] LTS_MID = CNT_W'(SYMBOL_LEN + 1);
    logic [CNT_W-1:0] seg_count;

    assign passing = ((state == ST_SYM_DATA) || (state == ST_LTS)) && !flush;
    assign framed.tlast = !flush &&
        (((state == ST_SYM_DATA) && seg_last) ||
         ((state == ST_LTS) && (seg_last || seg_count == LTS_MID)));
`else
    assign passing      = (state == ST_SYM_DATA) && !flush;
    assign framed.tlast = !flush && (state == ST_SYM_DATA) && seg_last;
`endif

    // Zero-latency pass-through while passing; drop (always ready) otherwise.
    assign framed.tdata   = samples.tdata;
    assign framed.tvalid  = passing & samples.tvalid;
    assign samples.tready = passing ? framed.tready : 1'b1;
    assign beat           = samples.tvalid & samples.tready;

    ofdm_seg_counter u_seg_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .load     (seg_load),
        .load_len (seg_len),
        .beat     (beat),
`ifdef OFDM_FRAME_SEQ_PREAMBLE_OUT_EN
        .count    (seg_count),
`else
        .count    (),
`endif
        .last     (seg_last)
    );

    // End-of-frame decision; a strobe arriving on the end beat is honoured.
    assign sym_end   = (state == ST_SYM_DATA) && seg_last && beat;
    assign n_hit     = frame_active && num_symbols_valid;
    assign n_known   = n_latched || n_hit;
    assign n_value   = n_latched ? n_value_q : num_symbols;
    assign max_eff   = (max_symbols == 8'd0) ? 8'd1 : max_symbols;
    assign done_ok   = n_known && (sym_idx >= n_value);
    assign timeout   = !n_known && (sym_idx >= max_eff);
    assign frame_end = sym_end && (done_ok || timeout) && !flush;
    assign eof       = frame_end;

    // State register.
    always_ff @(posedge clk) begin
        if (flush) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and segment reload on each segment's final beat.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_next = state;
        seg_load   = 1'b0;
        seg_len    = '0;
        unique case (state)
            ST_IDLE: begin
                if (beat && sof) begin
                    state_next = ST_LTS_GI;
                    seg_load   = 1'b1;
                    seg_len    = GI_LOAD;
                end
            end
            ST_LTS_GI: begin
                if (beat && seg_last) begin
                    state_next = ST_LTS;
                    seg_load   = 1'b1;
                    seg_len    = LTS_LOAD;
                end
            end
            ST_LTS: begin
                if (beat && seg_last) begin
                    state_next = ST_SYM_CP;
                    seg_load   = 1'b1;
                    seg_len    = CP_LOAD;
                end
            end
            ST_SYM_CP: begin
                if (beat && seg_last) begin
                    state_next = ST_SYM_DATA;
                    seg_load   = 1'b1;
                    seg_len    = SYM_LOAD;
                end
            end
            ST_SYM_DATA: begin
                if (sym_end) begin
                    if (done_ok || timeout) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_SYM_CP;
                        seg_load   = 1'b1;
                        seg_len    = CP_LOAD;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Symbol index and first-strobe-wins symbol-count latch, both per frame.
    always_ff @(posedge clk) begin
        if (flush) begin
            sym_idx   <= '0;
            n_latched <= 1'b0;
            n_value_q <= '0;
        end else begin
            if (n_hit && !n_latched) begin
                n_latched <= 1'b1;
                n_value_q <= num_symbols;
            end
            if (sym_end) begin
                if (done_ok || timeout) begin
                    sym_idx   <= '0;
                    n_latched <= 1'b0;
                end else begin
                    sym_idx <= sat_inc8(sym_idx);
                end
            end
        end
    end

    // Settings register and abort counter survive a soft clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_symbols <= MAX_SYMBOLS_RESET;
            abort_cnt   <= '0;
        end else begin
            if (set_stb && set_addr == SR_MAX_SYMBOLS) begin
                max_symbols <= set_data[7:0];
            end
            if (frame_end && timeout && abort_cnt != 16'hFFFF) begin
                abort_cnt <= abort_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
// Self-checking bench for ofdm_frame_sequencer. The expected stream is
// derived from each input beat's position within the frame; the frame
// length comes from the symbol-count / timeout rules.
module tb_ofdm_frame_sequencer;

    localparam int SL   = 64;
    localparam int CP   = 16;
    localparam int GI   = 32;
    localparam int HDR  = GI + 2 * SL;
    localparam int SYMW = CP + SL;
`ifdef OFDM_FRAME_SEQ_PREAMBLE_OUT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, clear, set_stb, sof, num_symbols_valid;
    logic [7:0]  set_addr, num_symbols;
    logic [31:0] set_data;
    logic        eof, frame_active;
    logic [15:0] abort_cnt;

    ofdm_frame_sequencer_if samples ();
    ofdm_frame_sequencer_if framed ();

    ofdm_frame_sequencer #(
        .SYMBOL_LEN        (SL),
        .CYCLIC_PREFIX_LEN (CP),
        .LTS_GI_LEN        (GI),
        .SR_MAX_SYMBOLS    (8'd0)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .clear             (clear),
        .set_stb           (set_stb),
        .set_addr          (set_addr),
        .set_data          (set_data),
        .samples           (samples),
        .sof               (sof),
        .num_symbols       (num_symbols),
        .num_symbols_valid (num_symbols_valid),
        .framed            (framed),
        .eof               (eof),
        .frame_active      (frame_active),
        .abort_cnt         (abort_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_abort = 0;
    int cur_max = 255;

    // Frame plan produced by plan_frame.
    int f_len, f_nsym;
    bit f_abort;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Symbol k ends at this frame-relative input beat.
    function automatic int sym_end_pos(input int k);
        return HDR + (k + 1) * SYMW - 1;
    endfunction

    // Number of symbols and timeout flag given strobe beat ps (-1: none) with
    // value n, and an optional max_symbols write (wpos/wval) during the frame.
    task automatic plan_frame(input int n, input int ps, input int wpos, input int wval);
        for (int k = 0; k < 300; k++) begin
            int e, m, ks;
            bit lat;
            e   = sym_end_pos(k);
            m   = (wpos >= 0 && wpos < e) ? wval : cur_max;
            m   = (m == 0) ? 1 : m;
            lat = (ps >= 0) && (ps <= e);
            ks  = (k > 255) ? 255 : k;
            if (lat && ks >= n) begin
                f_nsym = k + 1; f_abort = 1'b0; break;
            end
            if (!lat && ks >= m) begin
                f_nsym = k + 1; f_abort = 1'b1; break;
            end
        end
        f_len = HDR + f_nsym * SYMW;
    endtask

    function automatic bit is_pass(input int p);
        if (p < GI)  return 1'b0;
        if (p < HDR) return PRE;
        return ((p - HDR) % SYMW) >= CP;
    endfunction

    function automatic bit is_last(input int p);
        if (p < GI)  return 1'b0;
        if (p < HDR) return PRE && ((p - GI) == SL - 1 || (p - GI) == 2 * SL - 1);
        return ((p - HDR) % SYMW) == CP + SL - 1;
    endfunction

    task automatic idle_inputs();
        samples.tvalid    = 1'b0;
        samples.tdata     = '0;
        framed.tready     = 1'b1;
        sof               = 1'b0;
        num_symbols_valid = 1'b0;
        num_symbols       = '0;
        set_stb           = 1'b0;
        clear             = 1'b0;
    endtask

    task automatic write_max(input int v);
        @(posedge clk); #1;
        set_stb = 1'b1; set_addr = 8'd0; set_data = {$urandom} << 8 | 32'(v);
        @(posedge clk); #1;
        set_addr = 8'd1; set_data = 32'd0;           // other address: must be ignored
        @(posedge clk); #1;
        set_stb = 1'b0;
        cur_max = v;
    endtask

    // One frame: strobe n at beat ps, ignored strobe n2 at ps2, max write at
    // wpos, soft clear in place of beat clear_pos, random gaps/backpressure.
    task automatic run_frame(input int n, input int ps, input int n2, input int ps2,
                             input int wpos, input int wval, input int clear_pos,
                             input int gap_pct, input int bp_pct, input bit resof);
        int  p = 0;
        int  cycles = 0;
        int  budget;
        bit  s1 = 0, s2 = 0, w = 0;
        bit  hs;
        plan_frame(n, ps, wpos, wval);
        budget = 20 * f_len + 200;
        // Stray strobe while idle must not be latched.
        @(posedge clk); #1;
        idle_inputs();
        num_symbols_valid = 1'b1; num_symbols = 8'd200;
        @(negedge clk);
        check("idle_active", frame_active, 1'b0);
        while (p < f_len) begin
            @(posedge clk); #1;
            idle_inputs();
            if (p == clear_pos) begin
                clear = 1'b1;
                @(negedge clk);
                check("clr_eof", eof, 1'b0);
                check("clr_tlast", framed.tlast, 1'b0);
                @(posedge clk); #1;
                clear = 1'b0;
                @(negedge clk);
                check("clr_idle", frame_active, 1'b0);
                check("clr_abort", abort_cnt, 16'(exp_abort));
                return;
            end
            samples.tvalid = ($urandom_range(99) >= gap_pct);
            samples.tdata  = $urandom;
            framed.tready  = ($urandom_range(99) >= bp_pct);
            sof            = (p == 0) ? 1'b1 : (resof && $urandom_range(9) == 0);
            if (p == ps && !s1) begin
                num_symbols_valid = 1'b1; num_symbols = 8'(n); s1 = 1;
            end else if (p == ps2 && !s2) begin
                num_symbols_valid = 1'b1; num_symbols = 8'(n2); s2 = 1;
            end
            if (p == wpos && !w) begin
                set_stb = 1'b1; set_addr = 8'd0; set_data = 32'(wval); w = 1;
            end
            @(negedge clk);
            check("frame_active", frame_active, p > 0);
            hs = samples.tvalid && samples.tready;
            if (samples.tvalid && is_pass(p)) begin
                check("in_ready", samples.tready, framed.tready);
                check("out_valid", framed.tvalid, 1'b1);
                if (hs) begin
                    check("out_data", framed.tdata, samples.tdata);
                    check("out_last", framed.tlast, is_last(p));
                    check("eof", eof, p == f_len - 1);
                end else begin
                    check("eof_stall", eof, 1'b0);
                end
            end else begin
                check("drop_valid", framed.tvalid, 1'b0);
                check("drop_eof", eof, 1'b0);
                if (samples.tvalid) check("drop_ready", samples.tready, 1'b1);
            end
            if (hs) p++;
            cycles++;
            if (cycles > budget) begin
                check("cycle_budget", cycles, budget);
                break;
            end
        end
        if (wpos >= 0) cur_max = wval;
        if (f_abort) exp_abort++;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("end_idle", frame_active, 1'b0);
        check("abort_cnt", abort_cnt, 16'(exp_abort));
    endtask

    initial begin
        idle_inputs();
        samples.tlast = 1'b0;
        set_addr = '0; set_data = '0;
        reset = 1'b1;
        samples.tvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_active", frame_active, 1'b0);
        check("rst_abort", abort_cnt, 16'd0);
        check("rst_valid", framed.tvalid, 1'b0);
        check("rst_tlast", framed.tlast, 1'b0);
        check("rst_eof", eof, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();

        // Default stimulus: N=3 strobed in symbol 1, continuous samples.
        run_frame(3, HDR + SYMW + CP + 5, 0, -1, -1, 0, -1, 0, 0, 1'b0);
        // N=0 strobed on the SIGNAL tlast beat.
        run_frame(0, sym_end_pos(0), 0, -1, -1, 0, -1, 0, 0, 1'b0);
        // Late small N: ends at the next symbol end.
        run_frame(1, HDR + 3 * SYMW + CP + 2, 9, HDR + 3 * SYMW + CP + 3, -1, 0, -1, 0, 0, 1'b0);
        // Timeout after max_symbols=2.
        write_max(2);
        run_frame(0, -1, 0, -1, -1, 0, -1, 10, 10, 1'b0);
        // max_symbols rewritten to 1 mid-frame takes effect at the next end.
        run_frame(0, -1, 0, -1, HDR + CP + 10, 1, -1, 0, 0, 1'b0);
        // max_symbols=0 behaves as 1.
        write_max(0);
        run_frame(0, -1, 0, -1, -1, 0, -1, 0, 0, 1'b0);
        write_max(255);
        // Re-sof mid-frame, then clear at SYM_DATA beat 10; then recovery.
        run_frame(2, HDR + 5, 0, -1, -1, 0, HDR + CP + 10, 0, 0, 1'b1);
        run_frame(2, HDR + 5, 0, -1, -1, 0, -1, 0, 0, 1'b1);
        // Random gaps, backpressure, strobe timing and ignored second strobe.
        for (int i = 0; i < 4; i++) begin
            int n, ps;
            n  = $urandom_range(1, 4);
            ps = $urandom_range(1, HDR + (n + 2) * SYMW);
            run_frame(n, ps, $urandom_range(0, 255), ps + 1 + $urandom_range(0, 50),
                      -1, 0, -1, 30, 30, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ofdm_frame_sequencer.md
OFDM_FRAME_SEQUENCER -- requirements
Module: ofdm_frame_sequencer

Interface
REQ-001 Parameter SYMBOL_LEN, default 64: FFT samples per OFDM symbol.
REQ-002 Parameter CYCLIC_PREFIX_LEN, default 16: cyclic-prefix samples per symbol.
REQ-003 Parameter LTS_GI_LEN, default 32: long-preamble guard samples preceding the two long training symbols.
REQ-004 Parameter SR_MAX_SYMBOLS, default 0: settings-bus address of the max-symbols register.
REQ-005 The ports SHALL be as follows:
- clk  in  1: single clock; all logic on the rising edge.
- reset  in  1: synchronous, active-high.
- clear  in  1: synchronous soft clear.
- set_stb / set_addr / set_data  in  1/8/32: settings bus.
- i_tdata / i_tvalid / i_tready  in/in/out  32/1/1: aligned samples, I in [31:16], Q in [15:0].
- sof  in  1: marks the current input beat as the first long-preamble sample.
- num_symbols / num_symbols_valid  in  8/1: decoded data-symbol count and its strobe.
- o_tdata / o_tlast / o_tvalid / o_tready  out/out/out/in  32/1/1/1: symbol-framed output.
- eof  out  1: end-of-frame pulse.
- frame_active  out  1: high while in any state other than IDLE.
- abort_cnt  out  16: count of timed-out frames.

Function
REQ-006 The block SHALL have the states IDLE, LTS_GI, LTS, SYM_CP and SYM_DATA, and SHALL advance its counters only on an input beat (i_tvalid & i_tready).
REQ-007 Dropping states (IDLE, LTS_GI, SYM_CP, and LTS when the preamble is not forwarded) SHALL drive i_tready=1 and o_tvalid=0.
REQ-008 Passing states SHALL drive o_tdata=i_tdata, o_tvalid=i_tvalid and i_tready=o_tready, with zero-cycle latency and no data modification.
REQ-009 IDLE SHALL go to LTS_GI on a beat with sof=1, and that beat SHALL count as LTS_GI sample 0.
REQ-010 LTS_GI SHALL last LTS_GI_LEN beats, then go to LTS.
REQ-011 LTS SHALL last 2*SYMBOL_LEN beats, then go to SYM_CP.
REQ-012 SYM_CP SHALL last CYCLIC_PREFIX_LEN beats, then go to SYM_DATA.
REQ-013 SYM_DATA SHALL last SYMBOL_LEN beats and SHALL assert o_tlast on the last beat.
REQ-014 At the end of SYM_DATA the block SHALL go to IDLE if the end condition holds, otherwise to SYM_CP.
REQ-015 The first SYM_DATA symbol after LTS SHALL be the SIGNAL symbol (sym_idx 0), and sym_idx SHALL increment at each SYM_DATA end, saturating at 255.
REQ-016 num_symbols_valid SHALL latch num_symbols only when frame_active=1 and no value is already latched; later strobes in the same frame SHALL be ignored.
REQ-017 The end condition SHALL be: a value N is latched and sym_idx >= N; the case N <= sym_idx at latch time SHALL end the frame at the next SYM_DATA end, and N=0 SHALL end the frame after the SIGNAL symbol.
REQ-018 A strobe coinciding with a SYM_DATA end beat SHALL be included in that beat's end-condition evaluation.
REQ-019 Timeout: if no value is latched and sym_idx reaches max_symbols at a SYM_DATA end, the frame SHALL end and abort_cnt SHALL increment, saturating at 0xFFFF.
REQ-020 eof SHALL be a one-cycle pulse coincident with the o_tlast beat of the frame's final symbol.
REQ-021 sof while not in IDLE SHALL be ignored.
REQ-022 i_tvalid=0 in mid-symbol SHALL stall all counters with no state loss.
REQ-023 The max_symbols register SHALL be written when set_stb=1 and set_addr=SR_MAX_SYMBOLS (bits [7:0]); it SHALL reset to 255, and a value of 0 SHALL be treated as 1.
REQ-024 A max_symbols write during a frame SHALL take effect at the next SYM_DATA end.

Reset
REQ-025 On reset: state=IDLE, counters=0, latch cleared, o_tvalid=0, o_tlast=0, eof=0, frame_active=0, abort_cnt=0, max_symbols=255.
REQ-026 clear SHALL behave as reset except that abort_cnt and max_symbols are preserved.
REQ-027 A frame interrupted by reset or clear SHALL emit no eof and no o_tlast.

Configuration
REQ-028 With OFDM_FRAME_SEQ_PREAMBLE_OUT_EN defined, LTS SHALL be a passing state with o_tlast at beats SYMBOL_LEN-1 and 2*SYMBOL_LEN-1.
REQ-029 Without OFDM_FRAME_SEQ_PREAMBLE_OUT_EN, LTS SHALL drop all its beats.

Structure
REQ-030 The state encoding and the SR_MAX_SYMBOLS default address SHALL live in the shared OFDM constants package, ofdm_pkg.
REQ-031 Per-state beat counting SHALL be one sub-module, ofdm_seg_counter (load length, decrement on beat, last flag).
REQ-032 The block SHALL contain no FIFO.

Verification
REQ-033 Defaults, macro off, sof then continuous samples, num_symbols=3 strobed during symbol 1 -> 32+128+16 dropped; output 4 bursts of 64 beats each with o_tlast; eof on beat 256; IDLE afterwards.
REQ-034 Macro on, same stimulus -> two extra 64-beat bursts before SIGNAL; 384 output beats in total.
REQ-035 num_symbols=0 strobed on the SIGNAL o_tlast beat -> eof on that same beat; 64 output beats.
REQ-036 max_symbols=2 written, no strobe -> eof after 3 symbols; abort_cnt=1.
REQ-037 Random i_tvalid gaps and o_tready backpressure -> output data identical to the passing input beats; tlast positions unchanged.
REQ-038 sof re-asserted mid-frame, then clear at SYM_DATA beat 10 -> re-sof ignored; after clear, IDLE next cycle, no eof, abort_cnt unchanged.
